truth_table_sequencer: RTL

TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

---
 rtl/truth_table_sequencer.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/truth_table_sequencer.sv
// -----------------------------------------------------------------------------
// truth_table_sequencer
//
// Drives an exhaustive two-input truth table ({A,B} = 00, 01, 10, 11) into a
// De Morgan logic stage. It waits SETTLE_CYCLES cycles per vector, then
// compares the stage's packed outputs against built-in golden values and
// reports a pass/fail summary.
//
// Parameters
//   SETTLE_CYCLES  settle cycles per vector before sampling (1..15)
//
// Ports
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   one-cycle request for a full pass (ignored while busy)
//   obs[7:0]   in   {nA, nB, nAandnB, AorB, nAorB, AandB, nAandB, nAornB}
//   A, B       out  registered stimulus
//   busy       out  pass in progress
//   done       out  pass complete; held until the next accepted start
//   pass       out  done and no vector mismatched
//   fail_mask  out  bit i set when vector i mismatched
//   err_count  out  number of mismatching vectors (0..4)
//
// Optional build macro TTSEQ_FIRST_FAIL_EN adds:
//   first_fail_idx[1:0]  index of the first mismatching vector in the pass
//   first_fail_obs[7:0]  obs value captured at that first mismatch
// -----------------------------------------------------------------------------
module truth_table_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] obs,
  output logic       A,
  output logic       B,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask,
  output logic [2:0] err_count
`ifdef TTSEQ_FIRST_FAIL_EN
  ,
  output logic [1:0] first_fail_idx,
  output logic [7:0] first_fail_obs
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 32'd1);

  // Expected packed outputs for each vector index.
  function automatic logic [7:0] golden_obs(input logic [1:0] idx);
    logic [7:0] g;
    case (idx)
      2'd0:    g = 8'hEB;
      2'd1:    g = 8'h93;
      2'd2:    g = 8'h53;
      2'd3:    g = 8'h14;
      default: g = 8'h00;
    endcase
    return g;
  endfunction

  state_t     state_r,     state_s;
  logic [3:0] cnt_r,       cnt_s;
  logic [1:0] idx_r,       idx_s;
  logic       a_r,         a_s;
  logic       b_r,         b_s;
  logic       busy_r,      busy_s;
  logic       done_r,      done_s;
  logic       pass_r,      pass_s;
  logic [3:0] fail_mask_r, fail_mask_s;
  logic [2:0] err_r,       err_s;
  logic       mismatch_s;
`ifdef TTSEQ_FIRST_FAIL_EN
  logic [1:0] ff_idx_r,    ff_idx_s;
  logic [7:0] ff_obs_r,    ff_obs_s;
`endif

  // Next-state and next-output logic for the sequencer FSM.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    idx_s       = idx_r;
    a_s         = a_r;
    b_s         = b_r;
    busy_s      = busy_r;
    done_s      = done_r;
    pass_s      = pass_r;
    fail_mask_s = fail_mask_r;
    err_s       = err_r;
    mismatch_s  = (obs != golden_obs(idx_r));
`ifdef TTSEQ_FIRST_FAIL_EN
    ff_idx_s    = ff_idx_r;
    ff_obs_s    = ff_obs_r;
`endif

    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_s     = SETTLE;
          cnt_s       = 4'd0;
          idx_s       = 2'd0;
          a_s         = 1'b0;
          b_s         = 1'b0;
          busy_s      = 1'b1;
          done_s      = 1'b0;
          pass_s      = 1'b0;
          fail_mask_s = 4'd0;
          err_s       = 3'd0;
`ifdef TTSEQ_FIRST_FAIL_EN
          ff_idx_s    = 2'd0;
          ff_obs_s    = 8'd0;
`endif
        end else begin
          state_s = state_r;
        end
      end

      SETTLE: begin
        if (cnt_r == SETTLE_LAST) begin
          state_s = SAMPLE;
          cnt_s   = 4'd0;
        end else begin
          cnt_s   = cnt_r + 4'd1;
        end
      end

      SAMPLE: begin
        if (mismatch_s) begin
          fail_mask_s[idx_r] = 1'b1;
          // At most four vectors, so the 3-bit count never wraps.
          err_s = err_r + 3'd1;
`ifdef TTSEQ_FIRST_FAIL_EN
          if (err_r == 3'd0) begin
            ff_idx_s = idx_r;
            ff_obs_s = obs;
          end else begin
            ff_idx_s = ff_idx_r;
          end
`endif
        end else begin
          err_s = err_r;
        end

        if (idx_r == 2'd3) begin
          state_s = DONE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          pass_s  = (err_s == 3'd0);
        end else begin
          state_s = SETTLE;
          idx_s   = idx_r + 2'd1;
          a_s     = idx_s[1];
          b_s     = idx_s[0];
          cnt_s   = 4'd0;
        end
      end

      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      idx_r       <= 2'd0;
      a_r         <= 1'b0;
      b_r         <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      fail_mask_r <= 4'd0;
      err_r       <= 3'd0;
`ifdef TTSEQ_FIRST_FAIL_EN
      ff_idx_r    <= 2'd0;
      ff_obs_r    <= 8'd0;
`endif
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      idx_r       <= idx_s;
      a_r         <= a_s;
      b_r         <= b_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      pass_r      <= pass_s;
      fail_mask_r <= fail_mask_s;
      err_r       <= err_s;
`ifdef TTSEQ_FIRST_FAIL_EN
      ff_idx_r    <= ff_idx_s;
      ff_obs_r    <= ff_obs_s;
`endif
    end
  end

  assign A         = a_r;
  assign B         = b_r;
  assign busy      = busy_r;
  assign done      = done_r;
  // pass_r only ever goes high together with done_r; the gate makes it explicit.
  assign pass      = pass_r & done_r;
  assign fail_mask = fail_mask_r;
  assign err_count = err_r;
`ifdef TTSEQ_FIRST_FAIL_EN
  assign first_fail_idx = ff_idx_r;
  assign first_fail_obs = ff_obs_r;
`endif

endmodule
